alu_cmd_driver: RTL and testbench

//  Initiator for the registered 16-bit ALU (ALU_16B). Accepts operation commands over a

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_lat_counter.sv | 37 +++
 rtl/alu_cmd_driver.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU_16B command driver: function codes, flag bit
// positions and the driver state encoding.
package alu_pkg;

  localparam logic [3:0] FUN_ADD    = 4'b0000;
  localparam logic [3:0] FUN_SUB    = 4'b0001;
  localparam logic [3:0] FUN_MUL    = 4'b0010;
  localparam logic [3:0] FUN_DIV    = 4'b0011;
  localparam logic [3:0] FUN_AND    = 4'b0100;
  localparam logic [3:0] FUN_OR     = 4'b0101;
  localparam logic [3:0] FUN_NAND   = 4'b0110;
  localparam logic [3:0] FUN_NOR    = 4'b0111;
  localparam logic [3:0] FUN_XOR    = 4'b1000;
  localparam logic [3:0] FUN_XNOR   = 4'b1001;
  localparam logic [3:0] FUN_CMP_EQ = 4'b1010;
  localparam logic [3:0] FUN_CMP_GT = 4'b1011;
  localparam logic [3:0] FUN_CMP_LT = 4'b1100;
  localparam logic [3:0] FUN_SHR    = 4'b1101;
  localparam logic [3:0] FUN_SHL    = 4'b1110;
  localparam logic [3:0] FUN_IDLE   = 4'b1111;

  localparam int FLG_CARRY = 0;
  localparam int FLG_ARITH = 1;
  localparam int FLG_LOGIC = 2;
  localparam int FLG_CMP   = 3;
  localparam int FLG_SHIFT = 4;

  // Wide enough for ALU_LAT up to 7.
  localparam int LAT_CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic fun_is_legal(input logic [3:0] fun);
    return fun != FUN_IDLE;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the ALU's clocked latency; zero marks the
// edge on which the ALU result is valid.
module alu_lat_counter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LAT_CW-1:0] load_val,
  input  logic              dec,
  output logic [LAT_CW-1:0] count,
  output logic              zero
);

  logic [LAT_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Command initiator for the registered 16-bit ALU: issues one operation at a
// time, waits out the ALU latency and returns the tagged result.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [3:0]       CMD_FUN,
  input  logic [TAG_W-1:0] CMD_TAG,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic [4:0]       ALU_FLAGS,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [4:0]       RES_FLAGS,
  output logic [TAG_W-1:0] RES_TAG,
  output logic             RES_ERR,
  output logic [15:0]      OPS_CNT,
  output logic [1:0]       DBG_STATE
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Valid holds with stable payload until taken; ready never looks
  // at the partner's valid.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [4:0]       res_flags_q, res_flags_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;
  logic [15:0]      ops_cnt_q, ops_cnt_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [LAT_CW-1:0] cnt_val;

  alu_lat_counter u_lat_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (LAT_CW'(ALU_LAT)),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    ops_cnt_d   = ops_cnt_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          res_tag_d = CMD_TAG;
          if (fun_is_legal(CMD_FUN)) begin
            alu_a_d   = CMD_A;
            alu_b_d   = CMD_B;
            alu_fun_d = CMD_FUN;
            cnt_load  = 1'b1;
            ops_cnt_d = ops_cnt_q + 16'd1;
            state_d   = ST_WAIT;
          end else begin
            // Illegal code never reaches the ALU; report it directly.
            res_err_d   = 1'b1;
            res_data_d  = '0;
            res_flags_d = '0;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          res_data_d  = ALU_OUT;
          res_flags_d = ALU_FLAGS;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          alu_fun_d   = FUN_IDLE;
          state_d     = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FUN_IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      ops_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      ops_cnt_q   <= ops_cnt_d;
    end
  end

  // Ready is a pure state decode, masked so it reads low while reset is held.
  assign CMD_READY = (state_q == ST_IDLE) && !RST;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_FLAGS = res_flags_q;
  assign RES_TAG   = res_tag_q;
  assign RES_ERR   = res_err_q;
  assign OPS_CNT   = ops_cnt_q;
  assign DBG_STATE = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver paired with a behavioural registered ALU stub
// (one clock of latency); expected results come from the ALU rules directly.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int WIDTH   = 16;
  localparam int ALU_LAT = 1;
  localparam int TAG_W   = 4;
  localparam int RW      = 1 + TAG_W + 5 + WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [3:0]       cmd_fun;
  logic [TAG_W-1:0] cmd_tag;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_fun;
  logic [4:0]       alu_flags;
  logic             res_valid, res_ready, res_err;
  logic [WIDTH-1:0] res_data;
  logic [4:0]       res_flags;
  logic [TAG_W-1:0] res_tag;
  logic [15:0]      ops_cnt;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  logic [15:0]   ops_exp;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_cmd_driver #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_FUN(cmd_fun), .CMD_TAG(cmd_tag),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
    .ALU_OUT(alu_out), .ALU_FLAGS(alu_flags),
    .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_DATA(res_data), .RES_FLAGS(res_flags), .RES_TAG(res_tag),
    .RES_ERR(res_err), .OPS_CNT(ops_cnt), .DBG_STATE(dbg_state)
  );

  // ---------------- reference ALU rules: {flags, data}
  function automatic logic [20:0] alu_eval(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] fun);
    logic [16:0] s;
    logic [15:0] d;
    logic [4:0]  f;
    d = '0;
    f = '0;
    case (fun)
      FUN_ADD:    begin s = {1'b0, a} + {1'b0, b}; d = s[15:0]; f[FLG_CARRY] = s[16]; f[FLG_ARITH] = 1; end
      FUN_SUB:    begin d = a - b; f[FLG_CARRY] = (a < b); f[FLG_ARITH] = 1; end
      FUN_MUL:    begin d = 16'((32'(a) * 32'(b)) & 32'hFFFF); f[FLG_ARITH] = 1; end
      FUN_DIV:    begin d = (b != 0) ? a / b : 16'd0; f[FLG_ARITH] = 1; end
      FUN_AND:    begin d = a & b;    f[FLG_LOGIC] = 1; end
      FUN_OR:     begin d = a | b;    f[FLG_LOGIC] = 1; end
      FUN_NAND:   begin d = ~(a & b); f[FLG_LOGIC] = 1; end
      FUN_NOR:    begin d = ~(a | b); f[FLG_LOGIC] = 1; end
      FUN_XOR:    begin d = a ^ b;    f[FLG_LOGIC] = 1; end
      FUN_XNOR:   begin d = ~(a ^ b); f[FLG_LOGIC] = 1; end
      FUN_CMP_EQ: begin d = (a == b) ? 16'd1 : 16'd0; f[FLG_CMP] = 1; end
      FUN_CMP_GT: begin d = (a > b)  ? 16'd1 : 16'd0; f[FLG_CMP] = 1; end
      FUN_CMP_LT: begin d = (a < b)  ? 16'd1 : 16'd0; f[FLG_CMP] = 1; end
      FUN_SHR:    begin d = a >> 1;   f[FLG_SHIFT] = 1; end
      FUN_SHL:    begin d = a << 1;   f[FLG_SHIFT] = 1; end
      default:    begin d = '0; f = '0; end
    endcase
    return {f, d};
  endfunction

  always_ff @(posedge clk) begin
    {alu_flags, alu_out} <= alu_eval(alu_a, alu_b, alu_fun);
  end

  // ---------------- checker
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one command through to its result
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                        input logic [3:0] tag, input int hold, input logic keep_ready);
    int k;
    int low;
    logic legal;
    logic [RW-1:0] exp;
    logic [20:0] r;
    legal = (fun != FUN_IDLE);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_tag = tag;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check_val("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_fun = 4'($urandom); cmd_tag = 4'($urandom);
    r = alu_eval(a, b, fun);
    if (legal) begin
      exp = {1'b0, tag, r};
      ops_exp++;
    end else begin
      exp = {1'b1, tag, 21'd0};
    end
    exp_q.push_back(exp);

    k = 0;
    low = 0;
    do begin
      @(negedge clk);
      k++;
      if (!cmd_ready) low++;
      if (!res_valid && legal) begin
        check_val("alu_hold_a", 32'(alu_a), 32'(a));
        check_val("alu_hold_fun", 32'(alu_fun), 32'(fun));
      end
      if (!legal) check_val("alu_fun_illegal", 32'(alu_fun), 32'(FUN_IDLE));
    end while (!res_valid && k < 12);
    if (!res_valid) begin
      check_val("res_valid_timeout", 32'(res_valid), 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    check_val("res_latency", 32'(k), legal ? 32'(ALU_LAT + 2) : 32'd1);

    res_ready = keep_ready;
    for (int i = 0; i < hold; i++) begin
      check_val("bp_valid", 32'(res_valid), 32'd1);
      check_val("bp_data", 32'(res_data), 32'(exp[15:0]));
      check_val("bp_alu_fun", 32'(alu_fun), 32'(FUN_IDLE));
      @(negedge clk);
      if (!cmd_ready) low++;
    end

    exp = exp_q.pop_front();
    check_val("res_bundle", 32'({res_err, res_tag, res_flags, res_data}), 32'(exp));
    check_val("ops_cnt", 32'(ops_cnt), 32'(ops_exp));
    check_val("alu_fun_idle", 32'(alu_fun), 32'(FUN_IDLE));
    res_ready = 1'b1;
    @(negedge clk);
    check_val("res_valid_drop", 32'(res_valid), 32'd0);
    check_val("cmd_ready_back", 32'(cmd_ready), 32'd1);
    check_val("cmd_ready_low", 32'(low), legal ? 32'(ALU_LAT + 2 + hold) : 32'(1 + hold));
    res_ready = keep_ready;
  endtask

  // ---------------- stimulus
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fun = '0; cmd_tag = '0;
    res_ready = 1'b0;
    ops_exp = '0;
    #2;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_alu_fun", 32'(alu_fun), 32'(FUN_IDLE));
    check_val("rst_alu_a", 32'(alu_a), 32'd0);
    check_val("rst_res", 32'({res_valid, res_err, res_tag, res_flags, res_data}), 32'd0);
    check_val("rst_ops", 32'(ops_cnt), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic add, then back-to-back with result port always ready
    run_op(16'd15, 16'd20, FUN_ADD, 4'd3, 0, 1'b0);
    run_op(16'd10, 16'd8, FUN_SUB, 4'd4, 0, 1'b1);
    run_op(16'd26, 16'd26, FUN_CMP_EQ, 4'd5, 0, 1'b1);
    res_ready = 1'b0;
    // backpressure
    run_op(16'd23, 16'd54, FUN_AND, 4'd6, 10, 1'b0);
    // illegal code
    run_op(16'd1, 16'd2, FUN_IDLE, 4'd9, 0, 1'b0);
    run_op(16'h8000, 16'h8000, FUN_ADD, 4'd7, 2, 1'b0);

    // reset one cycle after accepting SHL
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 16'd31; cmd_b = 16'd0; cmd_fun = FUN_SHL; cmd_tag = 4'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(res_valid), 32'd0);
    check_val("mid_rst_alu_fun", 32'(alu_fun), 32'(FUN_IDLE));
    check_val("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check_val("mid_rst_ops", 32'(ops_cnt), 32'd0);
    check_val("mid_rst_ready", 32'(cmd_ready), 32'd0);
    check_val("mid_rst_tag", 32'(res_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ops_exp = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("post_rst_no_valid", 32'(res_valid), 32'd0);
    end

    // counter wrap
    @(negedge clk);
    force dut.ops_cnt_q = 16'hFFFF;
    #1 release dut.ops_cnt_q;
    ops_exp = 16'hFFFF;
    check_val("ops_preload", 32'(ops_cnt), 32'hFFFF);
    run_op(16'd100, 16'd7, FUN_DIV, 4'd11, 0, 1'b0);
    run_op(16'd3, 16'd0, FUN_IDLE, 4'd12, 1, 1'b0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
    end

    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
